// File: rtl/j_uart_pkg.sv
// Shared UART definitions for the j_txer transmitter and j_rxer receiver.
// Contents: frame constants, the bit-state enumeration and the parity helper.
package j_uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_FRAME_BITS     = UART_DATA_BITS + 2;
  localparam int UART_FRAME_BITS_PAR = UART_DATA_BITS + 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Even parity makes the total count of ones (data plus parity) even.
  function automatic logic parity(input logic [UART_DATA_BITS-1:0] data,
                                  input logic                      even);
    return even ? (^data) : (~^data);
  endfunction

endpackage

// File: rtl/j_txer_if.sv
// CPU-side and line-side signal bundle of the j_txer UART transmitter.
// The master modport is the bus/pad side; the slave modport is the transmitter.
interface j_txer_if;
  import j_uart_pkg::*;

  logic [UART_DATA_BITS-1:0] din;
  logic                      u2dwr;
  logic                      paren;
  logic                      even;
  logic                      txpol;
  logic                      txbrk;
  logic                      serout;
  logic                      tbe;
  logic                      tsre;

  modport master (
    output din, u2dwr, paren, even, txpol, txbrk,
    input  serout, tbe, tsre
  );

  modport slave (
    input  din, u2dwr, paren, even, txpol, txbrk,
    output serout, tbe, tsre
  );

endinterface

// File: rtl/j_txbaud.sv
// Gated bx16 divider: produces one bit_end pulse every OVERSAMPLE bx16 pulses
// while run is high, and holds its sub-count at zero while run is low.
module j_txbaud
  import j_uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic clk,
  input  logic resetl,
  input  logic bx16,
  input  logic run,
  output logic bit_end
);

  localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);

  logic [3:0] sub_q;

  assign bit_end = run & bx16 & (sub_q == LAST);

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      sub_q <= '0;
    end else if (!run) begin
      sub_q <= '0;
    end else if (bx16) begin
      sub_q <= bit_end ? 4'd0 : sub_q + 4'd1;
    end
  end

endmodule

// File: rtl/j_txer.sv
// UART transmitter: holding buffer, shift register and bit-state machine that
// serialise start, LSB-first data, optional parity and one stop bit.
module j_txer
  import j_uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       resetl,
  input  logic       bx16,
  j_txer_if.slave    bus
);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP   = STOP;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic [DATA_BITS-1:0] hold_q;
  logic                 tbe_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [2:0]           bit_idx_q;
  logic [2:0]           state_q;
  logic                 line_q;
  logic                 paren_q;
  logic                 par_bit_q;

  logic                 bit_end;
  logic                 load;

  j_txbaud #(.OVERSAMPLE(OVERSAMPLE)) u_baud (
    .clk     (clk),
    .resetl  (resetl),
    .bx16    (bx16),
    .run     (state_q != S_IDLE),
    .bit_end (bit_end)
  );

  // A pending byte starts from idle at once, or straight after the stop bit.
  assign load = ~tbe_q &
                ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_end));

  // Holding buffer: a write always wins over the load-side clearing of tbe.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      hold_q <= '0;
      tbe_q  <= 1'b1;
    end else if (bus.u2dwr) begin
      hold_q <= bus.din;
      tbe_q  <= 1'b0;
    end else if (load) begin
      tbe_q  <= 1'b1;
    end
  end

  // Parity is fixed at load time from the latched even/odd select.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q   <= S_IDLE;
      line_q    <= 1'b1;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      paren_q   <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (load) begin
      shreg_q   <= hold_q;
      paren_q   <= bus.paren;
      par_bit_q <= parity(hold_q, bus.even);
      bit_idx_q <= '0;
      state_q   <= S_START;
      line_q    <= 1'b0;
    end else if (bit_end) begin
      case (state_q)
        S_START: begin
          line_q    <= shreg_q[0];
          shreg_q   <= shreg_q >> 1;
          bit_idx_q <= '0;
          state_q   <= S_DATA;
        end
        S_DATA: begin
          if (bit_idx_q == LAST_BIT) begin
            if (paren_q) begin
              line_q  <= par_bit_q;
              state_q <= S_PARITY;
            end else begin
              line_q  <= 1'b1;
              state_q <= S_STOP;
            end
          end else begin
            line_q    <= shreg_q[0];
            shreg_q   <= shreg_q >> 1;
            bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        S_PARITY: begin
          line_q  <= 1'b1;
          state_q <= S_STOP;
        end
        S_STOP: begin
          line_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          line_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Break and polarity act on the registered line only, never on din/u2dwr.
  assign bus.serout = (line_q & ~bus.txbrk) ^ bus.txpol;
  assign bus.tbe    = tbe_q;
  assign bus.tsre   = (state_q == S_IDLE);

endmodule
